// File: rtl/sid_voice_sched.sv
// rtl/sid_voice_sched.sv - per-tick voice/stage sequencer with between-frame CPU write slot
// Frames of NUM_VOICES*STAGES datapath steps run per tick; CPU writes only commit from IDLE.
module sid_voice_sched #(
  parameter int NUM_VOICES = 3,
  parameter int STAGES     = 4,
  parameter int ADDR_W     = 5,
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ack,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_data,
  output logic              step_en,
  output logic [VW-1:0]     voice_sel,
  output logic [SW-1:0]     stage,
  output logic              frame_done,
  output logic              overrun,
  input  logic              clr_overrun
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, WRITE} state_t;

  state_t            state_q, state_d;
  logic              pend_q, pend_d;
  logic              overrun_q, overrun_d;
  logic [VW-1:0]     voice_q, voice_d;
  logic [SW-1:0]     stage_q, stage_d;
  logic              step_en_q, frame_done_q, reg_we_q;
  logic [ADDR_W-1:0] reg_addr_q;
  logic [7:0]        reg_data_q;

  logic last_stage, last_step;
  assign last_stage = (stage_q == SW'(STAGES - 1));
  assign last_step  = last_stage && (voice_q == VW'(NUM_VOICES - 1));

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    voice_d   = voice_q;
    stage_d   = stage_q;
    overrun_d = overrun_q;
    if (clr_overrun) overrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick || pend_q) begin
          state_d = RUN;
          voice_d = '0;
          stage_d = '0;
          // A tick arriving together with a pending one keeps the pending frame queued.
          if (!tick) pend_d = 1'b0;
        end else if (wr_req) begin
          state_d = WRITE;
        end
      end
      RUN: begin
        if (last_step) begin
          state_d = DONE;
          voice_d = '0;
          stage_d = '0;
        end else if (last_stage) begin
          stage_d = '0;
          voice_d = voice_q + 1'b1;
        end else begin
          stage_d = stage_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // One tick may be queued while busy; a second one is lost and flagged.
    if (tick && (state_q != IDLE)) begin
      if (pend_q) overrun_d = 1'b1;
      else        pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      overrun_q    <= 1'b0;
      voice_q      <= '0;
      stage_q      <= '0;
      step_en_q    <= 1'b0;
      frame_done_q <= 1'b0;
      reg_we_q     <= 1'b0;
      reg_addr_q   <= '0;
      reg_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      overrun_q    <= overrun_d;
      voice_q      <= voice_d;
      stage_q      <= stage_d;
      step_en_q    <= (state_d == RUN);
      frame_done_q <= (state_d == DONE);
      reg_we_q     <= (state_d == WRITE);
      if ((state_q == IDLE) && (state_d == WRITE)) begin
        reg_addr_q <= wr_addr;
        reg_data_q <= wr_data;
      end
    end
  end

  assign wr_ack     = reg_we_q;
  assign reg_we     = reg_we_q;
  assign reg_addr   = reg_addr_q;
  assign reg_data   = reg_data_q;
  assign step_en    = step_en_q;
  assign voice_sel  = voice_q;
  assign stage      = stage_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sid_voice_sched.sv
// tb/tb_sid_voice_sched.sv - vector table, corner sequences and random model check for sid_voice_sched
module tb_sid_voice_sched;
  localparam int NV = 3;
  localparam int ST = 4;
  localparam int N  = NV * ST;

  logic       clk = 1'b0, reset = 1'b1, tick = 1'b0, wr_req = 1'b0, clr_overrun = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       wr_ack, reg_we, step_en, frame_done, overrun;
  logic [4:0] reg_addr;
  logic [7:0] reg_data;
  logic [1:0] voice_sel, stage;

  int total = 0;
  int bad   = 0;

  sid_voice_sched #(.NUM_VOICES(NV), .STAGES(ST), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .tick(tick), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_data(reg_data), .step_en(step_en), .voice_sel(voice_sel), .stage(stage),
    .frame_done(frame_done), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tk, rq, clr;
    logic [4:0] a;
    logic [7:0] d;
    logic [21:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [21:0] mkexp(input logic se, input logic [1:0] v, input logic [1:0] s,
                                        input logic fd, input logic we, input logic ov,
                                        input logic [4:0] a, input logic [7:0] d);
    return {se, v, s, fd, we, we, ov, a, d};
  endfunction

  function automatic vec_t vec(input logic tk, input logic rq, input logic [4:0] a,
                               input logic [7:0] d, input logic [21:0] e);
    vec_t r;
    r.tk = tk; r.rq = rq; r.clr = 1'b0; r.a = a; r.d = d; r.exp = e;
    return r;
  endfunction

  function automatic logic [21:0] obs();
    return {step_en, voice_sel, stage, frame_done, reg_we, wr_ack, overrun, reg_addr, reg_data};
  endfunction

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [63:0] se_v, we_v, ack_v, fd_v, ov_v;

  // Runs n cycles with per-cycle tick/clear masks; bit k+1 of each record is the output after cycle k.
  task automatic watch(input int n, input logic [63:0] tm, input logic [63:0] cm);
    se_v = '0; we_v = '0; ack_v = '0; fd_v = '0; ov_v = '0;
    for (int k = 0; k < n; k++) begin
      tick = tm[k];
      clr_overrun = cm[k];
      step();
      se_v[k+1] = step_en; we_v[k+1] = reg_we; ack_v[k+1] = wr_ack;
      fd_v[k+1] = frame_done; ov_v[k+1] = overrun;
      if (wr_ack) wr_req = 1'b0;
    end
    tick = 1'b0;
    clr_overrun = 1'b0;
  endtask

  int         m_cnt;
  bit         m_wr, m_pend, m_ovr;
  logic [4:0] m_a;
  logic [7:0] m_d;

  // m_cnt: 0 = not framing, 1..N = step m_cnt-1 of the frame, N+1 = frame_done cycle.
  function automatic logic [21:0] model_exp();
    bit se = (m_cnt >= 1) && (m_cnt <= N);
    return mkexp(se, se ? 2'((m_cnt - 1) / ST) : 2'd0, se ? 2'((m_cnt - 1) % ST) : 2'd0,
                 m_cnt == N + 1, m_wr, m_ovr, m_a, m_d);
  endfunction

  task automatic model_step(input bit tk, input bit rq, input logic [4:0] a,
                            input logic [7:0] d, input bit clr);
    bit idle = (m_cnt == 0) && !m_wr;
    if (clr) m_ovr = 0;
    if (!idle && tk && m_pend) m_ovr = 1;
    if (idle) begin
      if (tk || m_pend) begin
        m_cnt = 1;
        if (!tk) m_pend = 0;
      end else if (rq) begin
        m_wr = 1; m_a = a; m_d = d;
      end
    end else begin
      m_wr = 0;
      if (m_cnt > 0) m_cnt = (m_cnt == N + 1) ? 0 : m_cnt + 1;
      if (tk) m_pend = 1;
    end
  endtask

  initial begin
    tbl.push_back(vec(1, 0, 5'h04, 8'h41, mkexp(1, 0, 0, 0, 0, 0, 5'h00, 8'h00)));
    for (int i = 1; i < N; i++)
      tbl.push_back(vec(0, i >= 3, 5'h04, 8'h41, mkexp(1, 2'(i / ST), 2'(i % ST), 0, 0, 0, 5'h00, 8'h00)));
    tbl.push_back(vec(0, 1, 5'h04, 8'h41, mkexp(0, 0, 0, 1, 0, 0, 5'h00, 8'h00)));
    tbl.push_back(vec(0, 1, 5'h04, 8'h41, mkexp(0, 0, 0, 0, 0, 0, 5'h00, 8'h00)));
    tbl.push_back(vec(0, 1, 5'h04, 8'h41, mkexp(0, 0, 0, 0, 1, 0, 5'h04, 8'h41)));
    tbl.push_back(vec(0, 0, 5'h04, 8'h41, mkexp(0, 0, 0, 0, 0, 0, 5'h04, 8'h41)));
    tbl.push_back(vec(0, 1, 5'h0a, 8'h7e, mkexp(0, 0, 0, 0, 1, 0, 5'h0a, 8'h7e)));
    tbl.push_back(vec(0, 0, 5'h0a, 8'h7e, mkexp(0, 0, 0, 0, 0, 0, 5'h0a, 8'h7e)));

    step(); step();
    chk("reset_state", obs(), 22'h0);
    reset = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      tick = tbl[i].tk; wr_req = tbl[i].rq; wr_addr = tbl[i].a;
      wr_data = tbl[i].d; clr_overrun = tbl[i].clr;
      step();
      chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
    end
    tick = 0; wr_req = 0;

    // tick and write request in the same idle cycle: frame first, write after
    wr_req = 1; wr_addr = 5'h13; wr_data = 8'hc3;
    watch(18, 64'h1, 64'h0);
    chk("tw_steps", se_v, rng(1, 12));
    chk("tw_done", fd_v, rng(13, 13));
    chk("tw_we", we_v, rng(15, 15));
    chk("tw_ack", ack_v, rng(15, 15));
    chk("tw_addr_data", {reg_addr, reg_data}, {5'h13, 8'hc3});

    // queued tick, lost tick, sticky overrun, clear, set-beats-clear
    watch(40, (64'h1 << 0) | (64'h1 << 5) | (64'h1 << 7) | (64'h1 << 32) | (64'h1 << 35) | (64'h1 << 37),
          (64'h1 << 30) | (64'h1 << 37));
    chk("ov_steps", se_v, rng(1, 12) | rng(15, 26) | rng(33, 40));
    chk("ov_done", fd_v, rng(13, 13) | rng(27, 27));
    chk("ov_flag", ov_v, rng(8, 30) | rng(38, 40));
    chk("ov_we", we_v, 64'h0);

    // reset mid-frame with a write pending
    reset = 1; step(); reset = 0;
    wr_req = 1; wr_addr = 5'h1f; wr_data = 8'ha5;
    watch(6, 64'h1, 64'h0);
    #2 reset = 1;
    #1 chk("rst_async", obs(), 22'h0);
    step();
    chk("rst_held", obs(), 22'h0);
    reset = 0;
    watch(18, 64'h1, 64'h0);
    chk("rst_steps", se_v, rng(1, 12));
    chk("rst_done", fd_v, rng(13, 13));
    chk("rst_ack", ack_v, rng(15, 15));
    chk("rst_addr_data", {reg_addr, reg_data}, {5'h1f, 8'ha5});

    // random traffic against the reference model
    reset = 1; wr_req = 0; tick = 0; clr_overrun = 0; step();
    m_cnt = 0; m_wr = 0; m_pend = 0; m_ovr = 0; m_a = 0; m_d = 0;
    reset = 0;
    for (int c = 0; c < 3000; c++) begin
      bit tk, rq, cl;
      if (wr_req && wr_ack) wr_req = 0;
      else if (!wr_req && $urandom_range(0, 3) == 0) begin
        wr_req = 1; wr_addr = 5'($urandom); wr_data = 8'($urandom);
      end
      tick = ($urandom_range(0, 9) == 0);
      clr_overrun = ($urandom_range(0, 15) == 0);
      tk = tick; rq = wr_req; cl = clr_overrun;
      step();
      model_step(tk, rq, wr_addr, wr_data, cl);
      chk($sformatf("rand%0d", c), obs(), model_exp());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
